// File: rtl/ahb_m2s_mux_pipe_if.sv
// AHB master-to-slave mux bundle: per-master requests in,
// muxed address/data phase plus burst tracker state out.
interface ahb_m2s_mux_pipe_if #(
  parameter int NUM_MASTERS  = 4,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MASTER_WIDTH = $clog2(NUM_MASTERS)
);
  localparam int SW = DATA_WIDTH / 8;

  logic [MASTER_WIDTH-1:0] Hmaster;
  logic                    Hready;
  logic                    Hresp;

  logic [ADDR_WIDTH-1:0]   Haddr_M     [NUM_MASTERS];
  logic [1:0]              Htrans_M    [NUM_MASTERS];
  logic                    Hwrite_M    [NUM_MASTERS];
  logic [2:0]              Hsize_M     [NUM_MASTERS];
  logic [2:0]              Hburst_M    [NUM_MASTERS];
  logic                    Hmastlock_M [NUM_MASTERS];
  logic [SW-1:0]           Hstrob_M    [NUM_MASTERS];
  logic [DATA_WIDTH-1:0]   Hwdata_M    [NUM_MASTERS];

  logic [ADDR_WIDTH-1:0]   Haddr;
  logic [1:0]              Htrans;
  logic                    Hwrite;
  logic [2:0]              Hsize;
  logic [2:0]              Hburst;
  logic                    Hmastlock;
  logic [SW-1:0]           Hstrob;
  logic [DATA_WIDTH-1:0]   Hwdata;
  logic [MASTER_WIDTH-1:0] Hmaster_d;
  logic                    burst_busy;
  logic [3:0]              beats_left;

  modport slave (
    input  Hmaster, Hready, Hresp,
    input  Haddr_M, Htrans_M, Hwrite_M, Hsize_M,
    input  Hburst_M, Hmastlock_M, Hstrob_M, Hwdata_M,
    output Haddr, Htrans, Hwrite, Hsize,
    output Hburst, Hmastlock, Hstrob, Hwdata,
    output Hmaster_d, burst_busy, beats_left
  );

  modport master (
    output Hmaster, Hready, Hresp,
    output Haddr_M, Htrans_M, Hwrite_M, Hsize_M,
    output Hburst_M, Hmastlock_M, Hstrob_M, Hwdata_M,
    input  Haddr, Htrans, Hwrite, Hsize,
    input  Hburst, Hmastlock, Hstrob, Hwdata,
    input  Hmaster_d, burst_busy, beats_left
  );
endinterface

// File: rtl/ahb_m2s_mux_pipe.sv
// AHB master-to-slave mux: address phase follows the grant,
// write data follows the registered data-phase owner.
module ahb_m2s_mux_pipe #(
  parameter int NUM_MASTERS  = 4,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MASTER_WIDTH = $clog2(NUM_MASTERS)
) (
  input logic Hclk,
  input logic Hresetn,
  ahb_m2s_mux_pipe_if.slave bus
);
  localparam int SW = DATA_WIDTH / 8;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] BUSY   = 2'b01;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;

  logic [MASTER_WIDTH-1:0] owner_q, owner_d;
  logic                    active_q, active_d;
  logic                    busy_q, busy_d;
  logic [3:0]              beats_q, beats_d;

  logic                  a_ok, d_ok;
  logic [ADDR_WIDTH-1:0] haddr;
  logic [1:0]            htrans;
  logic                  hwrite;
  logic [2:0]            hsize;
  logic [2:0]            hburst;
  logic                  hlock;
  logic [SW-1:0]         hstrob;
  logic [DATA_WIDTH-1:0] hwdata;

  function automatic logic [3:0] last_beat(
    input logic [2:0] b
  );
    logic [3:0] r;
    r = 4'd0;
    unique case (b)
      3'd2, 3'd3: r = 4'd3;
      3'd4, 3'd5: r = 4'd7;
      3'd6, 3'd7: r = 4'd15;
      default:    r = 4'd0;
    endcase
    return r;
  endfunction

  assign a_ok = int'(bus.Hmaster) < NUM_MASTERS;
  assign d_ok = int'(owner_q) < NUM_MASTERS;

  always_comb begin
    haddr  = '0;
    htrans = IDLE;
    hwrite = 1'b0;
    hsize  = 3'd0;
    hburst = 3'd0;
    hlock  = 1'b0;
    if (a_ok) begin
      haddr  = bus.Haddr_M[bus.Hmaster];
      htrans = bus.Htrans_M[bus.Hmaster];
      hwrite = bus.Hwrite_M[bus.Hmaster];
      hsize  = bus.Hsize_M[bus.Hmaster];
      hburst = bus.Hburst_M[bus.Hmaster];
      hlock  = bus.Hmastlock_M[bus.Hmaster];
    end
    // no transfer may leak onto the bus while reset is held
    if (!Hresetn) htrans = IDLE;
  end

  always_comb begin
    hstrob = '0;
    hwdata = '0;
    if (active_q && d_ok) begin
      hstrob = bus.Hstrob_M[owner_q];
      hwdata = bus.Hwdata_M[owner_q];
    end
  end

  logic acc, err1, fixed;
  logic ns_fix, ns_unf, seq_b, idle_b;

  assign acc    = bus.Hready;
  assign err1   = bus.Hresp & ~bus.Hready;
  assign fixed  = hburst[2:1] != 2'b00;
  assign ns_fix = acc & (htrans == NONSEQ) & fixed;
  assign ns_unf = acc & (htrans == NONSEQ) & ~fixed;
  assign seq_b  = acc & (htrans == SEQ) & busy_q;
  assign idle_b = acc & (htrans == IDLE) & busy_q;

  always_comb begin
    owner_d  = owner_q;
    active_d = active_q;
    busy_d   = busy_q;
    beats_d  = beats_q;
    if (bus.Hready) begin
      owner_d  = bus.Hmaster;
      active_d = htrans[1] & hwrite;
    end
    unique case (1'b1)
      err1: begin
        busy_d  = 1'b0;
        beats_d = 4'd0;
      end
      ns_fix: begin
        busy_d  = 1'b1;
        beats_d = last_beat(hburst);
      end
      ns_unf: begin
        busy_d  = 1'b0;
        beats_d = 4'd0;
      end
      seq_b: begin
        if (beats_q != 4'd0) begin
          beats_d = beats_q - 4'd1;
          busy_d  = beats_q != 4'd1;
        end else begin
          busy_d  = 1'b0;
        end
      end
      idle_b: begin
        busy_d  = 1'b0;
        beats_d = 4'd0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      owner_q  <= '0;
      active_q <= 1'b0;
      busy_q   <= 1'b0;
      beats_q  <= 4'd0;
    end else begin
      owner_q  <= owner_d;
      active_q <= active_d;
      busy_q   <= busy_d;
      beats_q  <= beats_d;
    end
  end

  assign bus.Haddr      = haddr;
  assign bus.Htrans     = htrans;
  assign bus.Hwrite     = hwrite;
  assign bus.Hsize      = hsize;
  assign bus.Hburst     = hburst;
  assign bus.Hmastlock  = hlock;
  assign bus.Hstrob     = hstrob;
  assign bus.Hwdata     = hwdata;
  assign bus.Hmaster_d  = owner_q;
  assign bus.burst_busy = busy_q;
  assign bus.beats_left = beats_q;
endmodule

// File: tb/tb_ahb_m2s_mux_pipe.sv
// Directed bench: stimulus queues expected outputs,
// a monitor pops and compares them on each sample point.
module tb_ahb_m2s_mux_pipe;
  localparam int NM = 3;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] BUSY   = 2'b01;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;

  localparam logic [5:0] C_TR = 6'd1;
  localparam logic [5:0] C_AD = 6'd2;
  localparam logic [5:0] C_WD = 6'd4;
  localparam logic [5:0] C_MD = 6'd8;
  localparam logic [5:0] C_BZ = 6'd16;
  localparam logic [5:0] C_BL = 6'd32;

  typedef struct {
    string       nm;
    logic [5:0]  m;
    logic [1:0]  tr;
    logic [31:0] ad;
    logic [31:0] wd;
    logic [1:0]  md;
    logic        bz;
    logic [3:0]  bl;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic smp_t = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t q[$];

  ahb_m2s_mux_pipe_if #(
    .NUM_MASTERS(NM), .ADDR_WIDTH(32),
    .DATA_WIDTH(32), .MASTER_WIDTH(2)
  ) bus ();

  ahb_m2s_mux_pipe #(
    .NUM_MASTERS(NM), .ADDR_WIDTH(32),
    .DATA_WIDTH(32), .MASTER_WIDTH(2)
  ) dut (
    .Hclk(clk),
    .Hresetn(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int m, input logic [1:0] tr,
                     input logic [31:0] ad, input logic wr,
                     input logic [2:0] bu, input logic [31:0] wd);
    bus.Htrans_M[m]    = tr;
    bus.Haddr_M[m]     = ad;
    bus.Hwrite_M[m]    = wr;
    bus.Hburst_M[m]    = bu;
    bus.Hwdata_M[m]    = wd;
    bus.Hsize_M[m]     = 3'd2;
    bus.Hstrob_M[m]    = 4'hF;
    bus.Hmastlock_M[m] = 1'b0;
  endtask

  task automatic push(input string nm, input logic [5:0] m,
                      input logic [1:0] tr, input logic [31:0] ad,
                      input logic [31:0] wd, input logic [1:0] md,
                      input logic bz, input logic [3:0] bl);
    exp_t e;
    e.nm = nm; e.m = m; e.tr = tr; e.ad = ad;
    e.wd = wd; e.md = md; e.bz = bz; e.bl = bl;
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input string f,
                     input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s.%s got=%0h exp=%0h", nm, f, got, want);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk or smp_t);
      while (q.size() > 0) begin
        e = q.pop_front();
        if (e.m[0]) chk(e.nm, "Htrans", 32'(bus.Htrans), 32'(e.tr));
        if (e.m[1]) chk(e.nm, "Haddr", bus.Haddr, e.ad);
        if (e.m[2]) chk(e.nm, "Hwdata", bus.Hwdata, e.wd);
        if (e.m[3]) chk(e.nm, "Hmaster_d", 32'(bus.Hmaster_d), 32'(e.md));
        if (e.m[4]) chk(e.nm, "burst_busy", 32'(bus.burst_busy), 32'(e.bz));
        if (e.m[5]) chk(e.nm, "beats_left", 32'(bus.beats_left), 32'(e.bl));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] tr_tab [8];
    logic [3:0] bl_tab [8];
    tr_tab = '{SEQ, SEQ, BUSY, SEQ, SEQ, SEQ, SEQ, SEQ};
    bl_tab = '{4'd7, 4'd6, 4'd5, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};

    bus.Hmaster = '0;
    bus.Hready  = 1'b1;
    bus.Hresp   = 1'b0;
    for (int i = 0; i < NM; i++) drv(i, IDLE, 32'h0, 1'b0, 3'd0, 32'h0);
    drv(0, NONSEQ, 32'h40, 1'b1, 3'd0, 32'h11);

    // reset state, with M0 trying to drive NONSEQ
    cyc();
    push("rst", C_TR|C_WD|C_MD|C_BZ|C_BL, IDLE, 0, 0, 0, 0, 0);

    // pipelining: M0 write, then grant moves to M1
    cyc();
    rst_n = 1'b1;
    drv(0, NONSEQ, 32'h100, 1'b1, 3'd0, 32'h0);
    push("p_addr0", C_TR|C_AD|C_BZ|C_BL, NONSEQ, 32'h100, 0, 0, 0, 0);
    cyc();
    bus.Hmaster = 2'd1;
    drv(0, IDLE, 32'h0, 1'b0, 3'd0, 32'hAAAA_5555);
    drv(1, NONSEQ, 32'h200, 1'b0, 3'd0, 32'h0);
    push("p_pipe", C_TR|C_AD|C_WD|C_MD, NONSEQ, 32'h200, 32'hAAAA_5555, 2'd0, 0, 0);
    cyc();
    drv(1, IDLE, 32'h204, 1'b0, 3'd0, 32'h1111);
    push("p_read", C_WD|C_MD, 0, 0, 32'h0, 2'd1, 0, 0);

    // wait states in M2 data phase while grant moves away
    cyc();
    bus.Hmaster = 2'd2;
    drv(2, NONSEQ, 32'h300, 1'b1, 3'd0, 32'h2222_2222);
    push("w_addr", C_TR|C_AD, NONSEQ, 32'h300, 0, 0, 0, 0);
    cyc();
    bus.Hmaster = 2'd3;
    bus.Hready  = 1'b0;
    drv(2, IDLE, 32'h0, 1'b0, 3'd0, 32'h2222_2222);
    push("w_hold1", C_TR|C_AD|C_WD|C_MD, IDLE, 0, 32'h2222_2222, 2'd2, 0, 0);
    cyc();
    push("w_hold2", C_WD|C_MD, 0, 0, 32'h2222_2222, 2'd2, 0, 0);
    cyc();
    bus.Hready = 1'b1;
    push("w_rel", C_WD|C_MD, 0, 0, 32'h2222_2222, 2'd2, 0, 0);

    // out-of-range grant with every master requesting
    cyc();
    drv(0, NONSEQ, 32'h400, 1'b1, 3'd0, 32'hD0);
    drv(1, NONSEQ, 32'h500, 1'b1, 3'd0, 32'hD1);
    drv(2, NONSEQ, 32'h600, 1'b1, 3'd0, 32'hD2);
    push("oor_addr", C_TR|C_AD|C_WD|C_MD, IDLE, 32'h0, 32'h0, 2'd3, 0, 0);
    cyc();
    push("oor_data", C_WD|C_MD, 0, 0, 32'h0, 2'd3, 0, 0);

    // INCR8 from M1 with a BUSY after beat 3
    cyc();
    bus.Hmaster = 2'd1;
    for (int i = 0; i < NM; i++) drv(i, IDLE, 32'h0, 1'b0, 3'd0, 32'h0);
    drv(1, NONSEQ, 32'h800, 1'b1, 3'd5, 32'h0);
    push("i8_ns", C_BZ|C_BL, 0, 0, 0, 0, 1'b0, 4'd0);
    for (int k = 0; k < 8; k++) begin
      cyc();
      drv(1, tr_tab[k], 32'h800 + 32'(4 * k), 1'b1, 3'd5, 32'h0);
      push($sformatf("i8_%0d", k), C_BZ|C_BL, 0, 0, 0, 0, 1'b1, bl_tab[k]);
    end
    cyc();
    drv(1, IDLE, 32'h0, 1'b0, 3'd0, 32'h0);
    push("i8_done", C_BZ|C_BL, 0, 0, 0, 0, 1'b0, 4'd0);

    // WRAP4 from M0 terminated by ERROR on beat 2
    cyc();
    bus.Hmaster = 2'd0;
    drv(0, NONSEQ, 32'hA00, 1'b1, 3'd2, 32'h0);
    push("w4_ns", C_BZ|C_BL, 0, 0, 0, 0, 1'b0, 4'd0);
    cyc();
    drv(0, SEQ, 32'hA04, 1'b1, 3'd2, 32'h0);
    push("w4_seq", C_BZ|C_BL, 0, 0, 0, 0, 1'b1, 4'd3);
    cyc();
    bus.Hready = 1'b0;
    bus.Hresp  = 1'b1;
    drv(0, SEQ, 32'hA08, 1'b1, 3'd2, 32'h0);
    push("w4_err", C_BZ|C_BL, 0, 0, 0, 0, 1'b1, 4'd2);
    cyc();
    bus.Hready = 1'b1;
    drv(0, IDLE, 32'h0, 1'b0, 3'd0, 32'h0);
    push("w4_clr", C_BZ|C_BL, 0, 0, 0, 0, 1'b0, 4'd0);
    cyc();
    bus.Hresp = 1'b0;
    push("w4_after", C_BZ|C_BL, 0, 0, 0, 0, 1'b0, 4'd0);

    // INCR4 from M2, reset asserted during beat 2
    cyc();
    bus.Hmaster = 2'd2;
    drv(2, NONSEQ, 32'hC00, 1'b1, 3'd3, 32'h3333);
    push("r4_ns", C_TR|C_BZ|C_BL, NONSEQ, 0, 0, 0, 1'b0, 4'd0);
    cyc();
    drv(2, SEQ, 32'hC04, 1'b1, 3'd3, 32'h3333);
    push("r4_seq", C_TR|C_WD|C_MD|C_BZ|C_BL, SEQ, 0, 32'h3333, 2'd2, 1'b1, 4'd3);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    push("r4_rst", C_TR|C_WD|C_MD|C_BZ|C_BL, IDLE, 0, 32'h0, 2'd0, 1'b0, 4'd0);
    smp_t = ~smp_t;
    cyc();
    cyc();
    rst_n = 1'b1;
    bus.Hmaster = 2'd0;
    for (int i = 0; i < NM; i++) drv(i, IDLE, 32'h0, 1'b0, 3'd0, 32'h0);
    push("post_rst", C_TR|C_MD|C_BZ|C_BL, IDLE, 0, 0, 2'd0, 1'b0, 4'd0);
    cyc();
    cyc();

    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got=%0d exp=0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
